// File: rtl/ysyx_23060332_ifu_pkg.sv
// Shared constants for the fetch/decode front end: bus widths, reset PC,
// the NOP/EBREAK encodings and the IFU state encoding.
package ysyx_23060332_ifu_pkg;

    localparam int          INST_BUS_W      = 32;
    localparam int          INST_ADDR_BUS_W = 32;
    localparam logic [31:0] IFU_RESET_PC    = 32'h8000_0000;
    localparam logic [31:0] INST_NOP        = 32'h0000_0013;
    localparam logic [31:0] INST_EBREAK     = 32'h0010_0073;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_ERR  = 2'd3
    } ifu_state_e;

endpackage

// File: rtl/ysyx_23060332_ifu_if.sv
// Instruction-memory read port: a request channel (address) and a response
// channel (data + error), each with its own valid/ready pair.
interface ysyx_23060332_ifu_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) ();
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic              imem_rsp_ready;
    logic [INST_W-1:0] imem_rsp_data;
    logic              imem_rsp_err;

    modport master (
        output imem_req_valid, imem_req_addr, imem_rsp_ready,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, imem_rsp_ready,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err
    );
endinterface

// File: rtl/ysyx_23060332_pc_reg.sv
// Program counter with redirect/sequential next-PC selection and a
// word-alignment check on the redirect target.
module ysyx_23060332_pc_reg
    import ysyx_23060332_ifu_pkg::*;
#(
    parameter int                ADDR_W   = INST_ADDR_BUS_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFU_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_redirect_valid,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_misaligned
);
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;

    // A redirect always beats the sequential step; pc+4 wraps naturally.
    always_comb begin
        w_pc_next = r_pc;
        if (i_redirect_valid) begin
            w_pc_next = i_redirect_pc;
        end else if (i_advance) begin
            w_pc_next = r_pc + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc         = r_pc;
    assign o_misaligned = i_redirect_valid && (i_redirect_pc[1:0] != 2'b00);
endmodule

// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: one outstanding imem read at a time, holds the
// fetched word toward decode until accepted, squashes fetches on redirect.
module ysyx_23060332_ifu
    import ysyx_23060332_ifu_pkg::*;
#(
    parameter int                ADDR_W   = INST_ADDR_BUS_W,
    parameter int                INST_W   = INST_BUS_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFU_RESET_PC)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    ysyx_23060332_ifu_if.master        imem,
    output logic [INST_W-1:0]          inst_o,
    output logic [ADDR_W-1:0]          inst_addr_o,
    output logic                       inst_valid_o,
    input  logic                       inst_ready_i,
    input  logic                       redirect_valid_i,
    input  logic [ADDR_W-1:0]          redirect_pc_i,
    output logic                       fetch_err_o
);
    ifu_state_e        r_state, w_state_next;
    logic              r_drop, w_drop_next;
    logic              r_err_pend, w_err_pend_next;
    logic              r_fetch_err, w_fetch_err_next;
    logic [INST_W-1:0] r_inst;
    logic [ADDR_W-1:0] r_inst_addr;
    logic              w_latch;
    logic [ADDR_W-1:0] w_pc;
    logic              w_misaligned;
    logic              w_req_fire;
    logic              w_rsp_fire;
    logic              w_accept;
    logic [INST_W-1:0] w_rsp_word;

    assign w_req_fire = (r_state == ST_REQ)  && imem.imem_req_ready;
    assign w_rsp_fire = (r_state == ST_WAIT) && imem.imem_rsp_valid;
    assign w_accept   = (r_state == ST_HOLD) && inst_ready_i;
    assign w_rsp_word = imem.imem_rsp_err ? INST_W'(INST_EBREAK) : imem.imem_rsp_data;

    ysyx_23060332_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_redirect_valid (redirect_valid_i),
        .i_redirect_pc    (redirect_pc_i),
        .i_advance        (w_accept),
        .o_pc             (w_pc),
        .o_misaligned     (w_misaligned)
    );

    // Next-state logic. A misaligned redirect seen while a read is in flight
    // is remembered in r_err_pend and only takes effect once that read drains.
    always_comb begin
        w_state_next     = r_state;
        w_drop_next      = r_drop;
        w_err_pend_next  = r_err_pend;
        w_fetch_err_next = r_fetch_err;
        w_latch          = 1'b0;
        case (r_state)
            ST_REQ: begin
                if (w_req_fire) begin
                    w_state_next = ST_WAIT;
                    if (redirect_valid_i) begin
                        w_drop_next     = 1'b1;
                        w_err_pend_next = w_misaligned;
                    end
                end else if (w_misaligned) begin
                    w_state_next     = ST_ERR;
                    w_fetch_err_next = 1'b1;
                end
            end
            ST_WAIT: begin
                if (w_rsp_fire) begin
                    w_drop_next     = 1'b0;
                    w_err_pend_next = 1'b0;
                    if (redirect_valid_i) begin
                        w_state_next     = w_misaligned ? ST_ERR : ST_REQ;
                        w_fetch_err_next = w_misaligned;
                    end else if (r_drop) begin
                        w_state_next     = r_err_pend ? ST_ERR : ST_REQ;
                        w_fetch_err_next = r_err_pend;
                    end else begin
                        w_state_next = ST_HOLD;
                        w_latch      = 1'b1;
                    end
                end else if (redirect_valid_i) begin
                    w_drop_next     = 1'b1;
                    w_err_pend_next = w_misaligned;
                end
            end
            ST_HOLD: begin
                if (redirect_valid_i) begin
                    w_state_next     = w_misaligned ? ST_ERR : ST_REQ;
                    w_fetch_err_next = w_misaligned;
                end else if (inst_ready_i) begin
                    w_state_next = ST_REQ;
                end
            end
            ST_ERR: begin
                if (redirect_valid_i && !w_misaligned) begin
                    w_state_next     = ST_REQ;
                    w_fetch_err_next = 1'b0;
                end
            end
            default: w_state_next = ST_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_REQ;
            r_drop      <= 1'b0;
            r_err_pend  <= 1'b0;
            r_fetch_err <= 1'b0;
            r_inst      <= INST_W'(INST_NOP);
            r_inst_addr <= '0;
        end else begin
            r_state     <= w_state_next;
            r_drop      <= w_drop_next;
            r_err_pend  <= w_err_pend_next;
            r_fetch_err <= w_fetch_err_next;
            if (w_latch) begin
                r_inst      <= w_rsp_word;
                r_inst_addr <= w_pc;
            end
        end
    end

    // Gated by rst_n so the bus sees no request while reset is held.
    assign imem.imem_req_valid = (r_state == ST_REQ) && rst_n;
    assign imem.imem_req_addr  = w_pc;
    assign imem.imem_rsp_ready = (r_state == ST_WAIT);
    assign inst_o              = r_inst;
    assign inst_addr_o         = r_inst_addr;
    assign inst_valid_o        = (r_state == ST_HOLD);
    assign fetch_err_o         = r_fetch_err;
endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Directed testbench for the fetch unit with a small behavioural imem model
// that answers each accepted request after a programmable number of cycles.
module tb_ysyx_23060332_ifu;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        fetch_err_o;

    int assertCount = 0;
    int failCount   = 0;

    ysyx_23060332_ifu_if bus ();

    ysyx_23060332_ifu dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem             (bus),
        .inst_o           (inst_o),
        .inst_addr_o      (inst_addr_o),
        .inst_valid_o     (inst_valid_o),
        .inst_ready_i     (inst_ready_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .fetch_err_o      (fetch_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] ERR_ADDR = 32'h8000_0008;

    function automatic logic [31:0] memData(input logic [31:0] addr);
        case (addr)
            32'h8000_0000: memData = 32'h0000_0093;
            32'h8000_0004: memData = 32'h0010_0093;
            default:       memData = {addr[15:0], 16'h0013};
        endcase
    endfunction

    // Memory model, evaluated on the falling edge: first retire the handshakes
    // that happened on the previous rising edge, then drive the response side.
    int          rspDelay = 0;
    int          reqCount = 0;
    bit          memPending;
    int          memCnt;
    logic [31:0] memAddr;
    bit          reqFirePending;
    bit          rspFirePending;
    logic [31:0] reqAddrSeen;

    always @(negedge clk) begin
        if (!rst_n) begin
            memPending         = 1'b0;
            reqFirePending     = 1'b0;
            rspFirePending     = 1'b0;
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_err   = 1'b0;
            bus.imem_rsp_data  = '0;
        end else begin
            if (rspFirePending) bus.imem_rsp_valid = 1'b0;
            if (reqFirePending) begin
                memPending = 1'b1;
                memCnt     = rspDelay;
                memAddr    = reqAddrSeen;
                reqCount++;
            end
            if (memPending && !bus.imem_rsp_valid) begin
                if (memCnt == 0) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = memData(memAddr);
                    bus.imem_rsp_err   = (memAddr == ERR_ADDR);
                    memPending         = 1'b0;
                end else begin
                    memCnt--;
                end
            end
            reqFirePending = bus.imem_req_valid && bus.imem_req_ready;
            reqAddrSeen    = bus.imem_req_addr;
            rspFirePending = bus.imem_rsp_valid && bus.imem_rsp_ready;
        end
    end

    task automatic waitInstValid(input int maxCycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if (inst_valid_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        assertCount++;
        if (bus.imem_req_valid !== 1'b0 || bus.imem_rsp_ready !== 1'b0 || inst_valid_o !== 1'b0 || fetch_err_o !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_ctrl: req_valid=%b rsp_ready=%b inst_valid=%b fetch_err=%b, expected all 0",
                     bus.imem_req_valid, bus.imem_rsp_ready, inst_valid_o, fetch_err_o);
        end
        assertCount++;
        if (inst_o !== 32'h0000_0013 || inst_addr_o !== 32'h0 || bus.imem_req_addr !== 32'h8000_0000) begin
            failCount++;
            $display("[TB] FAIL reset_data: inst=%h addr=%h req_addr=%h, expected 00000013 00000000 80000000",
                     inst_o, inst_addr_o, bus.imem_req_addr);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_fetch();
        bit ok;
        @(negedge clk);
        assertCount++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0000) begin
            failCount++;
            $display("[TB] FAIL first_req: valid=%b addr=%h, expected 1 80000000", bus.imem_req_valid, bus.imem_req_addr);
        end
        @(negedge clk);
        assertCount++;
        if (inst_valid_o !== 1'b0 || bus.imem_rsp_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL wait_state: inst_valid=%b rsp_ready=%b, expected 0 1", inst_valid_o, bus.imem_rsp_ready);
        end
        @(negedge clk);
        assertCount++;
        if (inst_valid_o !== 1'b1 || inst_o !== 32'h0000_0093 || inst_addr_o !== 32'h8000_0000) begin
            failCount++;
            $display("[TB] FAIL first_inst: valid=%b inst=%h addr=%h, expected 1 00000093 80000000",
                     inst_valid_o, inst_o, inst_addr_o);
        end
        waitInstValid(10, ok);
        assertCount++;
        if (!ok || inst_o !== 32'h0010_0093 || inst_addr_o !== 32'h8000_0004) begin
            failCount++;
            $display("[TB] FAIL second_inst: seen=%b inst=%h addr=%h, expected 1 00100093 80000004", ok, inst_o, inst_addr_o);
        end
    endtask

    task automatic test_stall();
        inst_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            assertCount++;
            if (inst_valid_o !== 1'b1 || inst_o !== 32'h0010_0093 || inst_addr_o !== 32'h8000_0004 || bus.imem_req_valid !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL stall_hold[%0d]: valid=%b inst=%h addr=%h req_valid=%b, expected 1 00100093 80000004 0",
                         i, inst_valid_o, inst_o, inst_addr_o, bus.imem_req_valid);
            end
        end
        inst_ready_i = 1'b1;
        @(negedge clk);
        inst_ready_i = 1'b0;
        assertCount++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0008 || inst_valid_o !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL stall_release: req_valid=%b addr=%h inst_valid=%b, expected 1 80000008 0",
                     bus.imem_req_valid, bus.imem_req_addr, inst_valid_o);
        end
    endtask

    task automatic test_bus_err();
        bit ok;
        waitInstValid(10, ok);
        assertCount++;
        if (!ok || inst_o !== 32'h0010_0073 || inst_addr_o !== 32'h8000_0008) begin
            failCount++;
            $display("[TB] FAIL bus_err: seen=%b inst=%h addr=%h, expected 1 00100073 80000008", ok, inst_o, inst_addr_o);
        end
    endtask

    task automatic test_redirect_wait();
        bit found = 1'b0;
        bit leaked = 1'b0;
        rspDelay     = 2;
        inst_ready_i = 1'b1;
        @(negedge clk);
        inst_ready_i = 1'b0;
        assertCount++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_000C) begin
            failCount++;
            $display("[TB] FAIL seq_req: valid=%b addr=%h, expected 1 8000000c", bus.imem_req_valid, bus.imem_req_addr);
        end
        @(negedge clk);
        assertCount++;
        if (bus.imem_rsp_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL in_wait: rsp_ready=%b, expected 1", bus.imem_rsp_ready);
        end
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h8000_0100;
        @(negedge clk);
        redirect_valid_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (inst_valid_o !== 1'b0) leaked = 1'b1;
            if (bus.imem_req_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        assertCount++;
        if (leaked) begin
            failCount++;
            $display("[TB] FAIL wait_squash: inst_valid went to 1, expected dropped response to stay hidden");
        end
        assertCount++;
        if (!found || bus.imem_req_addr !== 32'h8000_0100) begin
            failCount++;
            $display("[TB] FAIL wait_redirect_req: seen=%b addr=%h, expected 1 80000100", found, bus.imem_req_addr);
        end
        rspDelay = 0;
    endtask

    task automatic test_redirect_hold();
        bit ok;
        inst_ready_i = 1'b0;
        waitInstValid(10, ok);
        assertCount++;
        if (!ok || inst_addr_o !== 32'h8000_0100 || inst_o !== 32'h0100_0013) begin
            failCount++;
            $display("[TB] FAIL target_fetch: seen=%b inst=%h addr=%h, expected 1 01000013 80000100", ok, inst_o, inst_addr_o);
        end
        inst_ready_i     = 1'b1;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h8000_0040;
        @(negedge clk);
        inst_ready_i     = 1'b0;
        redirect_valid_i = 1'b0;
        assertCount++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0040 || inst_valid_o !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL hold_redirect: req_valid=%b addr=%h inst_valid=%b, expected 1 80000040 0",
                     bus.imem_req_valid, bus.imem_req_addr, inst_valid_o);
        end
        waitInstValid(10, ok);
        assertCount++;
        if (!ok || inst_addr_o !== 32'h8000_0040 || inst_o !== 32'h0040_0013) begin
            failCount++;
            $display("[TB] FAIL hold_target_inst: seen=%b inst=%h addr=%h, expected 1 00400013 80000040", ok, inst_o, inst_addr_o);
        end
    endtask

    task automatic test_misalign();
        int startCount;
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h8000_0002;
        @(negedge clk);
        redirect_valid_i = 1'b0;
        startCount       = reqCount;
        assertCount++;
        if (fetch_err_o !== 1'b1 || inst_valid_o !== 1'b0 || bus.imem_req_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL misalign_enter: fetch_err=%b inst_valid=%b req_valid=%b, expected 1 0 0",
                     fetch_err_o, inst_valid_o, bus.imem_req_valid);
        end
        repeat (4) @(negedge clk);
        assertCount++;
        if (bus.imem_req_valid !== 1'b0 || fetch_err_o !== 1'b1 || reqCount !== startCount) begin
            failCount++;
            $display("[TB] FAIL misalign_sticky: req_valid=%b fetch_err=%b new_reqs=%0d, expected 0 1 0",
                     bus.imem_req_valid, fetch_err_o, reqCount - startCount);
        end
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h8000_0010;
        @(negedge clk);
        redirect_valid_i = 1'b0;
        assertCount++;
        if (fetch_err_o !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h8000_0010) begin
            failCount++;
            $display("[TB] FAIL misalign_exit: fetch_err=%b req_valid=%b addr=%h, expected 0 1 80000010",
                     fetch_err_o, bus.imem_req_valid, bus.imem_req_addr);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        rspDelay = 3;
        @(negedge clk);
        assertCount++;
        if (bus.imem_rsp_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL pre_reset_wait: rsp_ready=%b, expected 1", bus.imem_rsp_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        assertCount++;
        if (bus.imem_req_valid !== 1'b0 || bus.imem_rsp_ready !== 1'b0 || inst_valid_o !== 1'b0 || fetch_err_o !== 1'b0 ||
            inst_o !== 32'h0000_0013 || inst_addr_o !== 32'h0 || bus.imem_req_addr !== 32'h8000_0000) begin
            failCount++;
            $display("[TB] FAIL async_reset: req_valid=%b rsp_ready=%b valid=%b err=%b inst=%h addr=%h pc=%h, expected 0 0 0 0 00000013 00000000 80000000",
                     bus.imem_req_valid, bus.imem_rsp_ready, inst_valid_o, fetch_err_o, inst_o, inst_addr_o, bus.imem_req_addr);
        end
        repeat (2) @(posedge clk);
        rspDelay = 0;
        #2 rst_n = 1'b1;
        waitInstValid(10, ok);
        assertCount++;
        if (!ok || inst_addr_o !== 32'h8000_0000 || inst_o !== 32'h0000_0093) begin
            failCount++;
            $display("[TB] FAIL post_reset_fetch: seen=%b inst=%h addr=%h, expected 1 00000093 80000000", ok, inst_o, inst_addr_o);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n              = 1'b0;
        inst_ready_i       = 1'b1;
        redirect_valid_i   = 1'b0;
        redirect_pc_i      = '0;
        bus.imem_req_ready = 1'b1;
        test_reset();
        test_fetch();
        test_stall();
        test_bus_err();
        test_redirect_wait();
        test_redirect_hold();
        test_misalign();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
